// File: rtl/memory_write_dword.sv
// Splits one physical write request (1..4 bytes, within a 16-byte line)
// into one or two aligned 32-bit Avalon-MM write beats with byte enables.
module memory_write_dword (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_reset,
  input  logic        req_do,
  output logic        req_done,
  input  logic [31:0] req_address,
  input  logic [2:0]  req_length,
  input  logic [31:0] req_data,
  output logic [29:0] avm_address,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  input  logic        avm_waitrequest
);

  localparam int unsigned ADDR_W = 30;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned LEN_W  = 3;

  typedef enum logic [1:0] {IDLE, FIRST, SECOND, DONE} state_t;

  state_t state_q, state_d;

  // Captured beats; beat 2 only meaningful when split_q is set
  logic [ADDR_W-1:0] b1_addr_q, b2_addr_q;
  logic [BE_W-1:0]   b1_be_q, b2_be_q;
  logic [DATA_W-1:0] b1_data_q, b2_data_q;
  logic              split_q;
  logic              reset_waiting_q, reset_waiting_d;

  logic              capture;
  logic [1:0]        off;
  logic [LEN_W-1:0]  room, len1, len2;
  logic [BE_W-1:0]   calc_be1, calc_be2;
  logic [DATA_W-1:0] calc_data1, calc_data2;

  logic              avm_write_d, req_done_d;
  logic [ADDR_W-1:0] avm_address_d;
  logic [BE_W-1:0]   avm_byteenable_d;
  logic [DATA_W-1:0] avm_writedata_d;

  function automatic logic [BE_W-1:0] len_mask(input logic [LEN_W-1:0] n);
    case (n)
      3'd0:    len_mask = 4'b0000;
      3'd1:    len_mask = 4'b0001;
      3'd2:    len_mask = 4'b0011;
      3'd3:    len_mask = 4'b0111;
      default: len_mask = 4'b1111;
    endcase
  endfunction

  // Split the request at the dword boundary into two beat descriptors
  always_comb begin
    off        = req_address[1:0];
    room       = LEN_W'(3'd4 - {1'b0, off});
    len1       = (req_length > room) ? room : req_length;
    len2       = LEN_W'(req_length - len1);
    calc_be1   = BE_W'({4'b0000, len_mask(len1)} << off);
    calc_be2   = len_mask(len2);
    calc_data1 = DATA_W'(req_data << {off, 3'b000});
    calc_data2 = DATA_W'(req_data >> {len1, 3'b000});
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state, flush tracking and next values of the registered outputs
  always_comb begin
    state_d          = state_q;
    capture          = 1'b0;
    reset_waiting_d  = reset_waiting_q;
    avm_write_d      = 1'b0;
    avm_address_d    = '0;
    avm_byteenable_d = '0;
    avm_writedata_d  = '0;
    req_done_d       = 1'b0;

    case (state_q)
      IDLE: begin
        reset_waiting_d = 1'b0;
        if (req_do && !wr_reset) begin
          capture = 1'b1;
          state_d = (req_length != '0) ? FIRST : DONE;
        end
      end
      FIRST:   if (!avm_waitrequest) state_d = split_q ? SECOND : DONE;
      SECOND:  if (!avm_waitrequest) state_d = DONE;
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE && wr_reset) reset_waiting_d = 1'b1;

    case (state_d)
      FIRST: begin
        avm_write_d      = 1'b1;
        avm_address_d    = capture ? req_address[31:2] : b1_addr_q;
        avm_byteenable_d = capture ? calc_be1 : b1_be_q;
        avm_writedata_d  = capture ? calc_data1 : b1_data_q;
      end
      SECOND: begin
        avm_write_d      = 1'b1;
        avm_address_d    = b2_addr_q;
        avm_byteenable_d = b2_be_q;
        avm_writedata_d  = b2_data_q;
      end
      DONE:    req_done_d = !reset_waiting_d;
      default: ;
    endcase
  end

  // Beat capture, flush flag and registered bus/completion outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      b1_addr_q       <= '0;
      b1_be_q         <= '0;
      b1_data_q       <= '0;
      b2_addr_q       <= '0;
      b2_be_q         <= '0;
      b2_data_q       <= '0;
      split_q         <= 1'b0;
      reset_waiting_q <= 1'b0;
      avm_write       <= 1'b0;
      avm_address     <= '0;
      avm_byteenable  <= '0;
      avm_writedata   <= '0;
      req_done        <= 1'b0;
    end else begin
      if (capture) begin
        b1_addr_q <= req_address[31:2];
        b1_be_q   <= calc_be1;
        b1_data_q <= calc_data1;
        b2_addr_q <= ADDR_W'(req_address[31:2] + 30'd1);
        b2_be_q   <= calc_be2;
        b2_data_q <= calc_data2;
        split_q   <= (len2 != '0);
      end
      reset_waiting_q <= reset_waiting_d;
      avm_write       <= avm_write_d;
      avm_address     <= avm_address_d;
      avm_byteenable  <= avm_byteenable_d;
      avm_writedata   <= avm_writedata_d;
      req_done        <= req_done_d;
    end
  end

endmodule

// File: tb/tb_memory_write_dword.sv
// Directed + random bench for memory_write_dword with a beat scoreboard.
module tb_memory_write_dword;

  logic        clk, rst_n, wr_reset, req_do, req_done;
  logic [31:0] req_address, req_data, avm_writedata;
  logic [2:0]  req_length;
  logic [29:0] avm_address;
  logic        avm_write, avm_waitrequest;
  logic [3:0]  avm_byteenable;

  memory_write_dword dut (
    .clk(clk), .rst_n(rst_n), .wr_reset(wr_reset), .req_do(req_do),
    .req_done(req_done), .req_address(req_address), .req_length(req_length),
    .req_data(req_data), .avm_address(avm_address), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_waitrequest(avm_waitrequest)
  );

  typedef struct packed {
    logic [29:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0, errors = 0;
  int    cyc = 0, t0 = 0, done_cnt = 0, write_cycles = 0;
  bit    hold_valid = 0;
  beat_t held;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Byte-lane reference model: pushes the expected beats of one request
  task automatic send(input logic [31:0] a, input logic [2:0] len, input logic [31:0] d);
    beat_t b0, b1;
    logic [31:0] ba;
    int off, len1;
    assert (len <= 3'd4) else begin
      errors++;
      $error("FAIL illegal_length: observed %0d expected <= 4", len);
    end
    off  = int'(a[1:0]);
    len1 = (int'(len) < 4 - off) ? int'(len) : 4 - off;
    b0 = '0; b1 = '0;
    b0.addr = a[31:2];
    b1.addr = 30'(a[31:2] + 30'd1);
    for (int i = 0; i < int'(len); i++) begin
      ba = a + 32'(i);
      if (ba[31:2] == a[31:2]) b0.be[ba[1:0]] = 1'b1;
      else                     b1.be[ba[1:0]] = 1'b1;
    end
    for (int l = 0; l < 4; l++) begin
      if (l >= off)      b0.data[l*8 +: 8] = d[(l-off)*8 +: 8];
      if (l + len1 < 4)  b1.data[l*8 +: 8] = d[(l+len1)*8 +: 8];
    end
    if (b0.be != 4'b0) exp_q.push_back(b0);
    if (b1.be != 4'b0) exp_q.push_back(b1);
    req_address = a; req_length = len; req_data = d; req_do = 1'b1;
    t0 = cyc;
  endtask

  // One clock: score an accepted beat, check stall stability, then sample
  task automatic tick();
    beat_t e;
    bit hold_now;
    hold_now = 1'b0;
    if (avm_write && !avm_waitrequest && rst_n) begin
      if (exp_q.size() == 0) chk("beat_unexpected", 72'(exp_q.size()), 72'd1);
      else begin
        e = exp_q.pop_front();
        chk("beat_addr", 72'(avm_address), 72'(e.addr));
        chk("beat_be",   72'(avm_byteenable), 72'(e.be));
        chk("beat_data", 72'(avm_writedata), 72'(e.data));
      end
    end
    if (avm_write && avm_waitrequest && rst_n) begin
      hold_now = 1'b1;
      held = '{addr: avm_address, be: avm_byteenable, data: avm_writedata};
    end
    @(posedge clk); #1;
    cyc++;
    if (hold_now)
      chk("hold_stable", 72'({avm_write, avm_address, avm_byteenable, avm_writedata}),
          72'({1'b1, held}));
    if (req_done) done_cnt++;
    if (avm_write) write_cycles++;
  endtask

  // Run until req_done (upstream drops req_do on seeing it); bounded
  task automatic run_req(input int budget, input bit rnd_wait, output int lat);
    bit seen;
    seen = 1'b0; lat = -1;
    for (int i = 0; i < budget && !seen; i++) begin
      if (rnd_wait) avm_waitrequest = 1'($urandom_range(0, 1));
      tick();
      if (req_done) begin
        seen = 1'b1; lat = cyc - t0; req_do = 1'b0; avm_waitrequest = 1'b0;
      end
    end
    chk("req_done_seen", 72'(seen), 72'd1);
    if (seen) chk("beats_before_done", 72'(exp_q.size()), 72'd0);
    req_do = 1'b0; avm_waitrequest = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk(tag, 72'({avm_write, req_done, avm_address, avm_byteenable, avm_writedata}), 72'd0);
  endtask

  initial begin
    int lat, dc, wc;
    logic [31:0] ra;
    logic [2:0]  rl;
    int maxl;
    rst_n = 1'b0; wr_reset = 1'b0; req_do = 1'b0; avm_waitrequest = 1'b0;
    req_address = '0; req_length = '0; req_data = '0;
    repeat (3) tick();
    chk_idle("reset_outputs");
    rst_n = 1'b1;
    tick();
    chk_idle("idle_after_reset");

    // Aligned dword
    send(32'h1000, 3'd4, 32'hDDCCBBAA);
    tick();
    chk("t1_beat", 72'({avm_write, avm_address, avm_byteenable, avm_writedata}),
        72'({1'b1, 30'h400, 4'b1111, 32'hDDCCBBAA}));
    run_req(10, 1'b0, lat);
    chk("t1_latency", 72'(lat), 72'd2);
    tick();
    chk("t1_done_pulse", 72'(req_done), 72'd0);
    chk_idle("t1_idle");

    // Unaligned, inside one dword
    send(32'h1001, 3'd2, 32'h0000BBAA);
    tick();
    chk("t2_beat", 72'({avm_address, avm_byteenable, avm_writedata}),
        72'({30'h400, 4'b0110, 32'h00BBAA00}));
    run_req(10, 1'b0, lat);
    chk("t2_latency", 72'(lat), 72'd2);
    tick();

    // Dword cross with two wait cycles on beat 1
    wc = write_cycles; dc = done_cnt;
    send(32'h1003, 3'd4, 32'h44332211);
    avm_waitrequest = 1'b1;
    tick();
    chk("t3_beat1", 72'({avm_address, avm_byteenable, avm_writedata}),
        72'({30'h400, 4'b1000, 32'h11000000}));
    tick(); tick();
    avm_waitrequest = 1'b0;
    run_req(12, 1'b0, lat);
    chk("t3_latency", 72'(lat), 72'd5);
    chk("t3_write_cycles", 72'(write_cycles - wc), 72'd4);
    tick();
    chk("t3_done_count", 72'(done_cnt - dc), 72'd1);

    // Zero length
    wc = write_cycles;
    send(32'h1005, 3'd0, 32'h12345678);
    run_req(6, 1'b0, lat);
    chk("t4_latency", 72'(lat), 72'd1);
    tick();
    chk("t4_no_write", 72'(write_cycles - wc), 72'd0);

    // Flush during beat 1 of a split request
    wc = write_cycles; dc = done_cnt;
    send(32'h1002, 3'd4, 32'h44332211);
    tick();
    wr_reset = 1'b1; req_do = 1'b0;
    tick();
    wr_reset = 1'b0;
    repeat (5) tick();
    chk("t5_no_done", 72'(done_cnt - dc), 72'd0);
    chk("t5_beats_drained", 72'(exp_q.size()), 72'd0);
    chk("t5_write_cycles", 72'(write_cycles - wc), 72'd2);
    chk_idle("t5_idle");
    send(32'h2004, 3'd3, 32'hFFCCBBAA);
    run_req(10, 1'b0, lat);
    chk("t5_next_latency", 72'(lat), 72'd2);
    tick();

    // Request together with wr_reset in IDLE is ignored
    send(32'h2010, 3'd1, 32'h000000EE);
    wr_reset = 1'b1;
    tick();
    chk("t6_no_capture", 72'({avm_write, req_done}), 72'd0);
    wr_reset = 1'b0;
    t0 = cyc;
    tick();
    chk("t6_accept_write", 72'(avm_write), 72'd1);
    run_req(10, 1'b0, lat);
    chk("t6_latency", 72'(lat), 72'd2);
    tick();

    // Random requests within a 16-byte line with random stalls
    for (int n = 0; n < 24; n++) begin
      ra   = $urandom;
      maxl = 16 - int'(ra[3:0]);
      if (maxl > 4) maxl = 4;
      rl   = 3'($urandom_range(0, maxl));
      send(ra, rl, $urandom);
      run_req(40, 1'b1, lat);
      tick();
    end

    // Synchronous reset mid-operation truncates the beat
    send(32'h3001, 3'd4, 32'hA1B2C3D4);
    avm_waitrequest = 1'b1;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    chk_idle("rst_mid_op");
    exp_q.delete();
    req_do = 1'b0; avm_waitrequest = 1'b0;
    rst_n = 1'b1;
    tick();
    chk_idle("rst_mid_op_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
